pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control block for the program counter register; the counter samples `NewPC` when `WriteEnable` is high.
- Each cycle it chooses the next fetch address from four sources: sequential increment, branch target, jump target, or hold.
- It generates stall bubbles, a pipeline flush after a redirect, and halt/resume.
- It sits between the branch/jump resolution logic and hazard detection on one side and the PC register on the other.

Parameters:
- `MAX_ADDR`, 84: highest legal instruction byte address. Any `NewPC` above it is replaced by 0.
- `PC_STEP`, 4: sequential increment in bytes.
- `STALL_CYCLES`, 1: number of cycles `WriteEnable` is held low per `StallReq` pulse. Must be ≥1.
- `REDIRECT_BUBBLES`, 2: cycles after a redirect during which `Flush` stays high. Must be ≥0 and ≤15.

Ports:
- `Clock`, in, 1: rising-edge clock.
- `Reset`, in, 1: asynchronous, active-high. Forces state RUN and clears counters.
- `PC`, in, 32: current value of the PC register.
- `BranchTaken`, in, 1: resolved taken branch this cycle.
- `BranchTarget`, in, 32: branch destination.
- `Jump`, in, 1: jump this cycle.
- `JumpTarget`, in, 32: jump destination.
- `StallReq`, in, 1: hazard stall request (load-use).
- `Halt`, in, 1: stop fetch.
- `Resume`, in, 1: restart fetch from HALT.
- `NewPC`, out, 32: next PC value, combinational.
- `WriteEnable`, out, 1: PC register load enable, combinational.
- `Flush`, out, 1: squash the IF/ID stage, combinational.
- `State`, out, 2: RUN=0, STALL=1, REDIRECT=2, HALT=3.

Behaviour:
- Clocking:
  - `State` and the internal 4-bit counter `Cnt` are registered on the rising edge of `Clock`.
  - `NewPC`, `WriteEnable` and `Flush` are combinational from `State`, `Cnt`, `PC` and the request inputs, so the PC register updates on the same edge as the decision (zero added latency).
- Reset:
  - While `Reset`=1: `State`=RUN, `Cnt`=0, `WriteEnable`=0, `NewPC`=0, `Flush`=0.
  - Reset mid-STALL, mid-REDIRECT or in HALT aborts immediately; there is no residual stall or flush.
- Sequential address:
  - Computed as `PC`+`PC_STEP`, modulo 2^32.
- Wrap rule, applied last to every candidate:
  - If the candidate > `MAX_ADDR` (unsigned), `NewPC`=0.
  - `WriteEnable` is unchanged by the wrap.
- Default when `WriteEnable`=0: `NewPC` = sequential candidate (don't-care to the PC register, but driven deterministically).
- RUN, priority `Halt` > `Jump` > `BranchTaken` > `StallReq` > sequential:
  - `Halt`: `WriteEnable`=0, `Flush`=0; next state HALT.
  - `Jump`: `NewPC`=`JumpTarget`, `WriteEnable`=1, `Flush`=1. If `REDIRECT_BUBBLES`>1, next state REDIRECT with `Cnt`=`REDIRECT_BUBBLES`-1; otherwise stay in RUN.
  - `BranchTaken`: identical to `Jump`, using `BranchTarget`.
  - `StallReq`: `WriteEnable`=0. If `STALL_CYCLES`>1, next state STALL with `Cnt`=`STALL_CYCLES`-1; otherwise stay in RUN.
  - None of the above: sequential address, `WriteEnable`=1, `Flush`=0.
- STALL:
  - `WriteEnable`=0, `Flush`=0, `Cnt` decrements each cycle.
  - When `Cnt`==1 at the edge, next state is RUN.
  - `Halt` goes to HALT immediately.
  - `Jump`/`BranchTaken` abort the stall and redirect exactly as in RUN.
  - `StallReq` is ignored; it does not extend the stall.
- REDIRECT:
  - `Flush`=1, `WriteEnable`=1, `NewPC`=sequential address.
  - `BranchTaken`, `Jump` and `StallReq` are ignored, because they originate from squashed slots.
  - `Cnt` decrements; when `Cnt`==1 at the edge, next state is RUN.
  - `Halt` goes to HALT with `Flush`=1 in that cycle and `WriteEnable`=0.
- HALT:
  - `WriteEnable`=0, `Flush`=0.
  - `Resume`=1 and `Halt`=0: next state RUN. Fetch restarts sequentially from the held `PC` in the following cycle.
  - `Halt` and `Resume` both high: remain in HALT.
- `Flush` duration: for each redirect, `Flush` is high for max(1, `REDIRECT_BUBBLES`) consecutive cycles.
- Simultaneous `Jump` and `BranchTaken`: `Jump` wins and `BranchTarget` is discarded.

Test Plan:
- Reset=1 at `PC`=0x20 in STALL → `State`=0, `WriteEnable`=0, `NewPC`=0 with no clock edge; after release with `PC`=0 → `NewPC`=4, `WriteEnable`=1.
- `PC`=0x54 (84), no requests → `NewPC`=0, `WriteEnable`=1 (wrap); `PC`=0x50 → `NewPC`=0x54.
- `PC`=0x10, `BranchTaken`=1, `BranchTarget`=0x30 with `REDIRECT_BUBBLES`=2 → cycle 0: `NewPC`=0x30, `WriteEnable`=1, `Flush`=1. Cycle 1, `PC`=0x30, `BranchTaken`=1 (ignored): `NewPC`=0x34, `Flush`=1, `State`=2. Cycle 2: `Flush`=0, `State`=0.
- `STALL_CYCLES`=3, one-cycle `StallReq` at `PC`=0x08 → `WriteEnable`=0 for exactly 3 cycles, `PC` holds 0x08, then `NewPC`=0x0C. `Jump` to 0x40 in stall cycle 2 → `NewPC`=0x40, `WriteEnable`=1 immediately.
- `Jump`=1 and `BranchTaken`=1 together, `JumpTarget`=0x24, `BranchTarget`=0x3C → `NewPC`=0x24. `JumpTarget`=0x100 → `NewPC`=0.
- `Halt` at `PC`=0x18 → `WriteEnable`=0, `State`=3 for 5 cycles. `Halt`+`Resume` together → stays in HALT. `Resume` alone → `State`=0 next cycle, `NewPC`=0x1C, `WriteEnable`=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC selection and fetch control: chooses sequential, branch, jump or hold,
// and generates stall bubbles, post-redirect flush and halt/resume.
module pc_sequencer #(
  parameter int unsigned MAX_ADDR         = 84,
  parameter int unsigned PC_STEP          = 4,
  parameter int unsigned STALL_CYCLES     = 1,
  parameter int unsigned REDIRECT_BUBBLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        StallReq,
  input  logic        Halt,
  input  logic        Resume,
  output logic [31:0] NewPC,
  output logic        WriteEnable,
  output logic        Flush,
  output logic [1:0]  State
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  localparam logic          STALL_HOLD  = (STALL_CYCLES > 1);
  localparam logic          REDIR_HOLD  = (REDIRECT_BUBBLES > 1);
  localparam logic [CW-1:0] STALL_INIT  = STALL_HOLD ? CW'(STALL_CYCLES - 1) : CW'(0);
  localparam logic [CW-1:0] REDIR_INIT  = REDIR_HOLD ? CW'(REDIRECT_BUBBLES - 1) : CW'(0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] redir_tgt;
  logic [AW-1:0] cand;
  logic          redir_req;
  logic          we;
  logic          flush;

  assign seq_pc    = PC + AW'(PC_STEP);
  assign redir_req = Jump | BranchTaken;
  // Jump outranks a simultaneous taken branch
  assign redir_tgt = Jump ? JumpTarget : BranchTarget;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand    = seq_pc;
    we      = 1'b0;
    flush   = 1'b0;
    case (state_q)
      // RUN and STALL share halt/redirect handling; a stall only holds the PC
      ST_RUN, ST_STALL: begin
        if (Halt) begin
          state_d = ST_HALT;
          cnt_d   = '0;
        end else if (redir_req) begin
          cand  = redir_tgt;
          we    = 1'b1;
          flush = 1'b1;
          if (REDIR_HOLD) begin
            state_d = ST_REDIRECT;
            cnt_d   = REDIR_INIT;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end else if (state_q == ST_STALL) begin
          if (cnt_q <= CW'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else if (StallReq) begin
          if (STALL_HOLD) begin
            state_d = ST_STALL;
            cnt_d   = STALL_INIT;
          end
        end else begin
          we = 1'b1;
        end
      end
      // Requests here come from squashed slots and are ignored
      ST_REDIRECT: begin
        flush = 1'b1;
        if (Halt) begin
          state_d = ST_HALT;
          cnt_d   = '0;
        end else begin
          we = 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_HALT: begin
        if (Resume && !Halt) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign NewPC       = Reset ? '0 : ((cand > AW'(MAX_ADDR)) ? '0 : cand);
  assign WriteEnable = ~Reset & we;
  assign Flush       = ~Reset & flush;
  assign State       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// behavioural model tracking remaining stall/flush cycles and a halted flag.
module tb_pc_sequencer;

  localparam int unsigned MAX_ADDR         = 84;
  localparam int unsigned PC_STEP          = 4;
  localparam int unsigned STALL_CYCLES     = 3;
  localparam int unsigned REDIRECT_BUBBLES = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PC = '0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = '0;
  logic        StallReq = 1'b0;
  logic        Halt = 1'b0;
  logic        Resume = 1'b0;
  logic [31:0] NewPC;
  logic        WriteEnable;
  logic        Flush;
  logic [1:0]  State;

  pc_sequencer #(
    .MAX_ADDR(MAX_ADDR),
    .PC_STEP(PC_STEP),
    .STALL_CYCLES(STALL_CYCLES),
    .REDIRECT_BUBBLES(REDIRECT_BUBBLES)
  ) dut (
    .Clock(Clock), .Reset(Reset), .PC(PC),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .StallReq(StallReq), .Halt(Halt), .Resume(Resume),
    .NewPC(NewPC), .WriteEnable(WriteEnable), .Flush(Flush), .State(State)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: halted flag, PC-hold cycles still owed, flush cycles still owed
  int m_halted, m_stall, m_flush;
  int n_halted, n_stall, n_flush;
  logic [31:0] exp_np;
  logic        exp_we, exp_fl;
  int          exp_st;
  logic [31:0] pc_track;

  function automatic logic [31:0] wrap(input logic [31:0] a);
    return (a > MAX_ADDR) ? 32'd0 : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    logic [31:0] seq;
    seq = wrap(PC + 32'(PC_STEP));
    n_halted = m_halted; n_stall = m_stall; n_flush = m_flush;
    exp_st = (m_halted != 0) ? 3 : (m_flush > 0) ? 2 : (m_stall > 0) ? 1 : 0;
    exp_np = seq; exp_we = 1'b0; exp_fl = 1'b0;
    if (m_halted != 0) begin
      if (Resume && !Halt) n_halted = 0;
    end else if (m_flush > 0) begin
      exp_fl = 1'b1;
      if (Halt) begin n_halted = 1; n_flush = 0; end
      else begin exp_we = 1'b1; n_flush = m_flush - 1; end
    end else if (Halt) begin
      n_halted = 1; n_stall = 0;
    end else if (Jump || BranchTaken) begin
      exp_np  = wrap(Jump ? JumpTarget : BranchTarget);
      exp_we  = 1'b1; exp_fl = 1'b1; n_stall = 0;
      n_flush = ((REDIRECT_BUBBLES > 1) ? REDIRECT_BUBBLES : 1) - 1;
    end else if (m_stall > 0) begin
      n_stall = m_stall - 1;
    end else if (StallReq) begin
      n_stall = STALL_CYCLES - 1;
    end else begin
      exp_we = 1'b1;
    end
  endtask

  task automatic apply(input logic [31:0] pc, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic st,
                       input logic h, input logic r);
    @(negedge Clock);
    PC = pc; BranchTaken = br; BranchTarget = bt; Jump = j; JumpTarget = jt;
    StallReq = st; Halt = h; Resume = r;
    #1;
    model_eval();
    chk("NewPC", NewPC, exp_np);
    chk("WriteEnable", 32'(WriteEnable), 32'(exp_we));
    chk("Flush", 32'(Flush), 32'(exp_fl));
    chk("State", 32'(State), 32'(exp_st));
  endtask

  task automatic tick();
    @(posedge Clock);
    m_halted = n_halted; m_stall = n_stall; m_flush = n_flush;
    if (exp_we) pc_track = exp_np;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("rst_State", 32'(State), 32'd0);
    chk("rst_WriteEnable", 32'(WriteEnable), 32'd0);
    chk("rst_NewPC", NewPC, 32'd0);
    chk("rst_Flush", 32'(Flush), 32'd0);
    m_halted = 0; m_stall = 0; m_flush = 0; pc_track = '0;
    @(posedge Clock);
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    m_halted = 0; m_stall = 0; m_flush = 0; pc_track = '0;
    #3;
    do_reset();

    // Reset aborts a stall in progress
    apply(32'h20, 0, 0, 0, 0, 1, 0, 0); chk("stall_req_we", 32'(WriteEnable), 0); tick();
    apply(32'h20, 0, 0, 0, 0, 0, 0, 0); chk("in_stall_state", 32'(State), 1);
    do_reset();
    apply(32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_np", NewPC, 32'h4); chk("post_rst_we", 32'(WriteEnable), 1); tick();

    // Wrap rule
    apply(32'h54, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_np", NewPC, 32'h0); chk("wrap_we", 32'(WriteEnable), 1); tick();
    apply(32'h50, 0, 0, 0, 0, 0, 0, 0); chk("edge_np", NewPC, 32'h54); tick();
    apply(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0); chk("mod32_np", NewPC, 32'h0); tick();

    // Branch with two flush cycles; branch during REDIRECT ignored
    apply(32'h10, 1, 32'h30, 0, 0, 0, 0, 0);
    chk("br_np", NewPC, 32'h30); chk("br_fl", 32'(Flush), 1); tick();
    apply(32'h30, 1, 32'h08, 0, 0, 0, 0, 0);
    chk("redir_np", NewPC, 32'h34); chk("redir_fl", 32'(Flush), 1); chk("redir_st", 32'(State), 2); tick();
    apply(32'h34, 0, 0, 0, 0, 0, 0, 0);
    chk("after_fl", 32'(Flush), 0); chk("after_st", 32'(State), 0); tick();

    // Three-cycle stall, then a jump aborting a stall
    apply(32'h08, 0, 0, 0, 0, 1, 0, 0); chk("stall1_we", 32'(WriteEnable), 0); tick();
    apply(32'h08, 0, 0, 0, 0, 1, 0, 0); chk("stall2_we", 32'(WriteEnable), 0); tick();
    apply(32'h08, 0, 0, 0, 0, 0, 0, 0); chk("stall3_we", 32'(WriteEnable), 0); tick();
    apply(32'h08, 0, 0, 0, 0, 0, 0, 0);
    chk("unstall_np", NewPC, 32'h0C); chk("unstall_we", 32'(WriteEnable), 1); tick();
    apply(32'h08, 0, 0, 0, 0, 1, 0, 0); tick();
    apply(32'h08, 0, 0, 1, 32'h40, 0, 0, 0);
    chk("stall_jmp_np", NewPC, 32'h40); chk("stall_jmp_we", 32'(WriteEnable), 1); tick();
    apply(32'h40, 0, 0, 0, 0, 0, 0, 0); tick();

    // Jump beats branch; out-of-range jump wraps
    apply(32'h44, 1, 32'h3C, 1, 32'h24, 0, 0, 0); chk("jmp_prio_np", NewPC, 32'h24); tick();
    apply(32'h24, 0, 0, 0, 0, 0, 0, 0); tick();
    apply(32'h28, 0, 0, 1, 32'h100, 0, 0, 0);
    chk("jmp_wrap_np", NewPC, 32'h0); chk("jmp_wrap_we", 32'(WriteEnable), 1); tick();
    apply(32'h0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Halt, Halt+Resume holds, Resume alone restarts
    apply(32'h18, 0, 0, 0, 0, 0, 1, 0); chk("halt_we", 32'(WriteEnable), 0); tick();
    for (int k = 0; k < 5; k++) begin
      apply(32'h18, 0, 0, 0, 0, 0, 0, 0);
      chk("halted_st", 32'(State), 3); chk("halted_we", 32'(WriteEnable), 0); tick();
    end
    apply(32'h18, 0, 0, 0, 0, 0, 1, 1); tick();
    apply(32'h18, 0, 0, 0, 0, 0, 0, 1); chk("hr_st", 32'(State), 3); tick();
    apply(32'h18, 0, 0, 0, 0, 0, 0, 0);
    chk("resume_st", 32'(State), 0); chk("resume_np", NewPC, 32'h1C);
    chk("resume_we", 32'(WriteEnable), 1); tick();

    // Randomized traffic against the model
    pc_track = 32'h1C + 32'(PC_STEP);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, bt, jt;
      logic br, j, st, h, r;
      pc = ($urandom_range(0, 19) == 0) ? 32'($urandom) : pc_track;
      bt = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 23)) * 4;
      jt = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 23)) * 4;
      br = ($urandom_range(0, 99) < 10);
      j  = ($urandom_range(0, 99) < 6);
      st = ($urandom_range(0, 99) < 12);
      h  = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 99) < 30);
      apply(pc, br, bt, j, jt, st, h, r);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
